// File: rtl/floo_mcast_b_collect.sv
// rtl/floo_mcast_b_collect.sv - collects and merges multicast B responses per AXI write ID
// Optional feature: define FLOO_MCAST_B_ERR_STATS_EN to enable the merged-error counter on err_cnt_o.
module floo_mcast_b_collect #(
    parameter int unsigned  NumIds   = 4,
    parameter int unsigned  MaxDests = 4,
    parameter int unsigned  IdWidth  = $clog2(NumIds),
    localparam int unsigned CntWidth = $clog2(MaxDests + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                exp_valid_i,
    output logic                exp_ready_o,
    input  logic [IdWidth-1:0]  exp_id_i,
    input  logic [CntWidth-1:0] exp_cnt_i,
    input  logic                b_valid_i,
    output logic                b_ready_o,
    input  logic [IdWidth-1:0]  b_id_i,
    input  logic [1:0]          b_resp_i,
    output logic                b_valid_o,
    input  logic                b_ready_i,
    output logic [IdWidth-1:0]  b_id_o,
    output logic [1:0]          b_resp_o,
    output logic                unexp_o,
    output logic [15:0]         err_cnt_o
);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [CntWidth-1:0] CNT_MAX = CntWidth'(MaxDests);
    localparam logic [CntWidth-1:0] CNT_ONE = CntWidth'(1);

    typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, DONE = 2'd2} state_e;

    state_e              state_q [NumIds];
    state_e              state_d [NumIds];
    logic [CntWidth-1:0] cnt_q   [NumIds];
    logic [CntWidth-1:0] cnt_d   [NumIds];
    logic [1:0]          resp_q  [NumIds];
    logic [1:0]          resp_d  [NumIds];

    logic               hold_q, hold_d;
    logic [IdWidth-1:0] hold_id_q, hold_id_d;
    logic               unexp_q, unexp_d;

    logic                exp_id_ok, b_id_ok;
    logic                exp_fire, b_hit, out_fire;
    logic                any_done;
    logic [IdWidth-1:0]  lowest_id, sel_id;
    logic [CntWidth-1:0] exp_cnt_clip;

    // Accumulator starts at EXOKAY so it survives only if every response was EXOKAY.
    function automatic logic [1:0] merge_resp(input logic [1:0] acc, input logic [1:0] r);
        if (acc == RESP_DECERR || r == RESP_DECERR) return RESP_DECERR;
        if (acc == RESP_SLVERR || r == RESP_SLVERR) return RESP_SLVERR;
        if (acc == RESP_EXOKAY && r == RESP_EXOKAY) return RESP_EXOKAY;
        return RESP_OKAY;
    endfunction

    assign exp_id_ok    = 32'(exp_id_i) < NumIds;
    assign b_id_ok      = 32'(b_id_i) < NumIds;
    assign exp_fire     = exp_valid_i && exp_ready_o;
    assign b_hit        = b_valid_i && b_id_ok && (state_q[b_id_i] == COLLECT);
    assign out_fire     = any_done && b_ready_i;
    assign exp_cnt_clip = (exp_cnt_i > CNT_MAX) ? CNT_MAX : exp_cnt_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NumIds); i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
                resp_q[i]  <= RESP_OKAY;
            end
            hold_q    <= 1'b0;
            hold_id_q <= '0;
            unexp_q   <= 1'b0;
        end else begin
            for (int i = 0; i < int'(NumIds); i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                resp_q[i]  <= resp_d[i];
            end
            hold_q    <= hold_d;
            hold_id_q <= hold_id_d;
            unexp_q   <= unexp_d;
        end
    end

    // exp, B-in and B-out each act only on an entry in a distinct state, so they never collide.
    always_comb begin
        for (int i = 0; i < int'(NumIds); i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            resp_d[i]  = resp_q[i];
        end
        if (exp_fire) begin
            if (exp_cnt_i == '0) begin
                state_d[exp_id_i] = DONE;
                cnt_d[exp_id_i]   = '0;
                resp_d[exp_id_i]  = RESP_OKAY;
            end else begin
                state_d[exp_id_i] = COLLECT;
                cnt_d[exp_id_i]   = exp_cnt_clip;
                resp_d[exp_id_i]  = RESP_EXOKAY;
            end
        end
        if (b_hit) begin
            cnt_d[b_id_i]  = cnt_q[b_id_i] - CNT_ONE;
            resp_d[b_id_i] = merge_resp(resp_q[b_id_i], b_resp_i);
            if (cnt_q[b_id_i] == CNT_ONE) begin
                state_d[b_id_i] = DONE;
            end
        end
        if (out_fire) begin
            state_d[sel_id] = IDLE;
        end
        // A stalled selection is frozen so a lower-index completion cannot swap it out.
        hold_d    = any_done && !b_ready_i;
        hold_id_d = sel_id;
        unexp_d   = b_valid_i && !b_hit;
    end

    always_comb begin
        lowest_id = '0;
        any_done  = 1'b0;
        for (int i = int'(NumIds) - 1; i >= 0; i--) begin
            if (state_q[i] == DONE) begin
                lowest_id = IdWidth'(i);
                any_done  = 1'b1;
            end
        end
        sel_id      = hold_q ? hold_id_q : lowest_id;
        exp_ready_o = exp_id_ok && (state_q[exp_id_i] == IDLE);
        b_ready_o   = 1'b1;
        b_valid_o   = any_done;
        b_id_o      = any_done ? sel_id : '0;
        b_resp_o    = any_done ? resp_q[sel_id] : RESP_OKAY;
        unexp_o     = unexp_q;
    end

`ifdef FLOO_MCAST_B_ERR_STATS_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_cnt_q <= '0;
        end else if (out_fire && b_resp_o[1] && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_cnt_o = err_cnt_q;
`else
    assign err_cnt_o = '0;
`endif

endmodule
